// File: rtl/fetch_unit.sv
// -----------------------------------------------------------------------------
// fetch_unit
//
// Purpose:
//   Instruction fetch stage. After reset it spends one BOOT cycle idle. It then
//   requests the word at PC from instruction memory (FETCH) and waits for the
//   acknowledge. Next it presents the word to decode (HOLD) until downstream
//   accepts it, and finally advances PC by 4 or by the branch offset.
//
// Parameters:
//   WIDTH     - instruction / address / immediate width
//   RESET_PC  - first fetch address after reset
//
// Ports:
//   clk          in   single clock, rising edge
//   rst          in   asynchronous active-low reset
//   PCsrc        in   1 = next PC is PC+ImmOp, 0 = PC+4 (used on handshake only)
//   ImmOp        in   sign-extended branch offset
//   imem_req     out  instruction-memory read request
//   imem_addr    out  byte address of the current request
//   imem_ack     in   imem_rdata valid this cycle (ignored unless requesting)
//   imem_rdata   in   fetched instruction word
//   instr        out  registered instruction for decode
//   instr_valid  out  instr is valid
//   instr_ready  in   downstream accepts instr this cycle
//   PC           out  address of the instruction on instr
//   misalign     out  sticky misaligned-branch-target flag
//
// Configuration:
//   `define FETCH_MISALIGN_CHECK_EN to stop in HALT when a handshake would load
//   a PC with bits [1:0] != 0. Without it the target is loaded unchecked and
//   misalign is tied to 0.
// -----------------------------------------------------------------------------
module fetch_unit #(
   parameter int               WIDTH    = 32,
   parameter logic [WIDTH-1:0] RESET_PC = '0
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             PCsrc,
   input  logic [WIDTH-1:0] ImmOp,
   output logic             imem_req,
   output logic [WIDTH-1:0] imem_addr,
   input  logic             imem_ack,
   input  logic [WIDTH-1:0] imem_rdata,
   output logic [WIDTH-1:0] instr,
   output logic             instr_valid,
   input  logic             instr_ready,
   output logic [WIDTH-1:0] PC,
   output logic             misalign
);

   typedef enum logic [1:0] {
      S_BOOT,
      S_FETCH,
      S_HOLD,
      S_HALT
   } state_e;

   state_e           state_q;
   logic [WIDTH-1:0] pc_q;
   logic [WIDTH-1:0] instr_q;
   logic             req_q;
   logic             valid_q;
   logic [WIDTH-1:0] offset_d;
   logic [WIDTH-1:0] next_pc_d;

   // NOTE: every signal written here gets a value on every pass, so no latch is inferred.
   always_comb begin
      offset_d  = PCsrc ? ImmOp : WIDTH'(4);
      // Plain addition wraps modulo 2^WIDTH, which is the intended behaviour.
      next_pc_d = pc_q + offset_d;
   end

`ifdef FETCH_MISALIGN_CHECK_EN
   logic misalign_q;
`endif

   // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         // The asynchronous clear drops imem_req and instr_valid the moment reset
         // asserts. Any response still in flight is ignored, because BOOT does
         // not look at imem_ack.
         state_q    <= S_BOOT;
         pc_q       <= RESET_PC;
         instr_q    <= '0;
         req_q      <= 1'b0;
         valid_q    <= 1'b0;
`ifdef FETCH_MISALIGN_CHECK_EN
         misalign_q <= 1'b0;
`endif
      end else begin
         case (state_q)
            S_BOOT: begin
               state_q <= S_FETCH;
               req_q   <= 1'b1;
            end
            S_FETCH: begin
               if (imem_ack) begin
                  instr_q <= imem_rdata;
                  req_q   <= 1'b0;
                  valid_q <= 1'b1;
                  state_q <= S_HOLD;
               end
            end
            S_HOLD: begin
               // PCsrc/ImmOp matter only on this handshake edge.
               if (instr_ready) begin
                  valid_q <= 1'b0;
`ifdef FETCH_MISALIGN_CHECK_EN
                  if (next_pc_d[1:0] != 2'b00) begin
                     misalign_q <= 1'b1;
                     state_q    <= S_HALT;
                  end else begin
                     pc_q    <= next_pc_d;
                     req_q   <= 1'b1;
                     state_q <= S_FETCH;
                  end
`else
                  pc_q    <= next_pc_d;
                  req_q   <= 1'b1;
                  state_q <= S_FETCH;
`endif
               end
            end
            S_HALT: begin
               // Stuck until reset; req and valid are already low.
               state_q <= S_HALT;
            end
         endcase
      end
   end

   assign imem_req    = req_q;
   assign imem_addr   = pc_q;
   assign instr       = instr_q;
   assign instr_valid = valid_q;
   assign PC          = pc_q;

`ifdef FETCH_MISALIGN_CHECK_EN
   assign misalign = misalign_q;
`else
   assign misalign = 1'b0;
`endif

endmodule

// File: tb/tb_fetch_unit.sv
// -----------------------------------------------------------------------------
// tb_fetch_unit
//
// Self-checking bench for fetch_unit. A transaction-level model tracks what the
// fetch stage must be doing: idle after reset, requesting a word, presenting a
// word, or stopped. A compare process checks every output against that model
// on each falling edge. Directed sequences pin the model with literal values.
// Randomized fetch/hold delays and branch offsets then follow.
// Honors FETCH_MISALIGN_CHECK_EN the same way the design does.
// -----------------------------------------------------------------------------
module tb_fetch_unit;

   localparam logic [31:0] RST_PC = 32'h0000_0000;
`ifdef FETCH_MISALIGN_CHECK_EN
   localparam bit MIS_EN = 1'b1;
`else
   localparam bit MIS_EN = 1'b0;
`endif

   logic        clk;
   logic        rst;
   logic        PCsrc;
   logic [31:0] ImmOp;
   logic        imem_req;
   logic [31:0] imem_addr;
   logic        imem_ack;
   logic [31:0] imem_rdata;
   logic [31:0] instr;
   logic        instr_valid;
   logic        instr_ready;
   logic [31:0] PC;
   logic        misalign;

   int n_cmp = 0;
   int n_bad = 0;

   fetch_unit #(
      .WIDTH    (32),
      .RESET_PC (RST_PC)
   ) dut (
      .clk         (clk),
      .rst         (rst),
      .PCsrc       (PCsrc),
      .ImmOp       (ImmOp),
      .imem_req    (imem_req),
      .imem_addr   (imem_addr),
      .imem_ack    (imem_ack),
      .imem_rdata  (imem_rdata),
      .instr       (instr),
      .instr_valid (instr_valid),
      .instr_ready (instr_ready),
      .PC          (PC),
      .misalign    (misalign)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] want);
      n_cmp++;
      if (act !== want) begin
         n_bad++;
         $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, want, $time);
      end
   endtask

   // ---------------- behavioural model ----------------
   // m_phase: 0 idle after reset, 1 waiting for memory, 2 word on offer, 3 stopped
   int          m_phase;
   logic [31:0] m_pc;
   logic [31:0] m_instr;
   logic        m_mis;
   logic [31:0] m_target;

   assign m_target = m_pc + (PCsrc ? ImmOp : 32'd4);

   always @(posedge clk or negedge rst) begin
      if (!rst) begin
         m_phase <= 0;
         m_pc    <= RST_PC;
         m_instr <= 32'h0;
         m_mis   <= 1'b0;
      end else if (m_phase == 0) begin
         m_phase <= 1;
      end else if (m_phase == 1 && imem_ack) begin
         m_instr <= imem_rdata;
         m_phase <= 2;
      end else if (m_phase == 2 && instr_ready) begin
         if (MIS_EN && m_target[1:0] != 2'b00) begin
            m_mis   <= 1'b1;
            m_phase <= 3;
         end else begin
            m_pc    <= m_target;
            m_phase <= 1;
         end
      end
   end

   // ---------------- per-cycle compare ----------------
   always @(negedge clk) begin
      check("cyc_req",      {31'b0, imem_req},    {31'b0, m_phase == 1});
      check("cyc_valid",    {31'b0, instr_valid}, {31'b0, m_phase == 2});
      check("cyc_pc",       PC,                   m_pc);
      check("cyc_misalign", {31'b0, misalign},    {31'b0, m_mis});
      if (m_phase == 1 || !rst) check("cyc_addr", imem_addr, m_pc);
      if (m_phase == 2 || !rst) check("cyc_instr", instr, m_instr);
   end

   // ---------------- stimulus helpers ----------------
   task automatic fetch(input int delay, input logic [31:0] word, output logic [31:0] addr);
      int waited = 0;
      while (imem_req !== 1'b1 && waited < 20) begin
         @(negedge clk);
         waited++;
      end
      check("fetch_req_seen", {31'b0, imem_req}, 32'd1);
      addr = imem_addr;
      for (int k = 0; k < delay; k++) begin
         imem_ack   = 1'b0;
         imem_rdata = $urandom;
         @(negedge clk);
         check("req_stable",  {31'b0, imem_req}, 32'd1);
         check("addr_stable", imem_addr, addr);
      end
      imem_ack   = 1'b1;
      imem_rdata = word;
      @(negedge clk);
      imem_ack   = 1'b0;
      imem_rdata = $urandom;
      check("valid_after_ack", {31'b0, instr_valid}, 32'd1);
      check("instr_loaded", instr, word);
   endtask

   task automatic hold(input int delay, input logic ps, input logic [31:0] imm);
      int          waited = 0;
      logic [31:0] pc0;
      logic [31:0] in0;
      while (instr_valid !== 1'b1 && waited < 20) begin
         @(negedge clk);
         waited++;
      end
      check("hold_valid_seen", {31'b0, instr_valid}, 32'd1);
      pc0 = PC;
      in0 = instr;
      for (int k = 0; k < delay; k++) begin
         // Noise on every input that must be ignored while stalled.
         instr_ready = 1'b0;
         PCsrc       = 1'($urandom);
         ImmOp       = $urandom;
         imem_ack    = 1'($urandom);
         imem_rdata  = $urandom;
         @(negedge clk);
         check("hold_instr_stable", instr, in0);
         check("hold_pc_stable", PC, pc0);
         check("hold_no_req", {31'b0, imem_req}, 32'd0);
      end
      imem_ack    = 1'b0;
      instr_ready = 1'b1;
      PCsrc       = ps;
      ImmOp       = imm;
      @(negedge clk);
      instr_ready = 1'b0;
      PCsrc       = 1'($urandom);
      ImmOp       = $urandom;
      check("valid_drop", {31'b0, instr_valid}, 32'd0);
   endtask

   // ---------------- main sequence ----------------
   initial begin
      logic [31:0] a;
      logic [31:0] pc_before;
      int          waited;
      int          off;

      rst         = 1'b0;
      PCsrc       = 1'b0;
      ImmOp       = 32'h0;
      imem_ack    = 1'b0;
      imem_rdata  = 32'h0;
      instr_ready = 1'b0;

      repeat (3) @(negedge clk);
      check("rst_req",      {31'b0, imem_req},    32'd0);
      check("rst_valid",    {31'b0, instr_valid}, 32'd0);
      check("rst_pc",       PC,        RST_PC);
      check("rst_addr",     imem_addr, RST_PC);
      check("rst_instr",    instr,     32'h0);
      check("rst_misalign", {31'b0, misalign}, 32'd0);
      #1 rst = 1'b1;

      // Back-to-back sequential fetches.
      fetch(0, 32'h0000_0013, a); check("seq_addr0", a, 32'h0);  hold(0, 1'b0, 32'h0);
      fetch(0, 32'h0010_0093, a); check("seq_addr1", a, 32'h4);  hold(0, 1'b0, 32'h0);
      fetch(0, 32'h0020_0113, a); check("seq_addr2", a, 32'h8);  hold(0, 1'b0, 32'h0);
      fetch(0, 32'h0030_0193, a); check("seq_addr3", a, 32'hC);  hold(0, 1'b0, 32'h0);

      // Backward branch from 0x10 by -8.
      fetch(0, 32'hFE00_0CE3, a); check("br_src", a, 32'h10);
      hold(0, 1'b1, 32'hFFFF_FFF8);

      // Slow memory: four wait cycles before the ack.
      fetch(4, 32'hCAFE_0001, a); check("br_target", a, 32'h08);

      // Downstream stall of five cycles with PCsrc noise.
      hold(5, 1'b0, 32'h0);
      fetch(0, 32'hCAFE_0002, a); check("after_stall", a, 32'h0C);

      // Jump to the top of the address space, then wrap with PC+4.
      hold(0, 1'b1, 32'hFFFF_FFFC - 32'h0000_000C);
      fetch(0, 32'hCAFE_0003, a); check("top_addr", a, 32'hFFFF_FFFC);
      hold(0, 1'b0, 32'h0);

      // Reset in the middle of the fetch at the wrapped address.
      waited = 0;
      while (imem_req !== 1'b1 && waited < 20) begin
         @(negedge clk);
         waited++;
      end
      check("wrap_addr", imem_addr, 32'h0);
      #2 rst = 1'b0;
      #1;
      check("rst_drops_req",   {31'b0, imem_req},    32'd0);
      check("rst_drops_valid", {31'b0, instr_valid}, 32'd0);
      // A late response arriving around reset must be discarded.
      imem_ack   = 1'b1;
      imem_rdata = 32'hDEAD_BEEF;
      @(negedge clk);
      #1 rst = 1'b1;
      fetch(0, 32'h600D_F00D, a); check("refetch_addr", a, RST_PC);
      hold(0, 1'b0, 32'h0);

      // Random traffic with aligned branch offsets.
      repeat (250) begin
         fetch($urandom_range(0, 3), $urandom, a);
         off = int'($urandom_range(0, 64)) - 32;
         hold($urandom_range(0, 3), 1'($urandom_range(0, 1)), 32'(off * 4));
      end

      // Misaligned branch target (+2).
      fetch(0, 32'hBAD0_0002, pc_before);
      hold(0, 1'b1, 32'h0000_0002);
`ifdef FETCH_MISALIGN_CHECK_EN
      repeat (4) begin
         @(negedge clk);
         check("halt_misalign", {31'b0, misalign}, 32'd1);
         check("halt_no_req",   {31'b0, imem_req}, 32'd0);
         check("halt_pc",       PC, pc_before);
      end
`else
      fetch(0, 32'h0000_0013, a);
      check("unchecked_target", a, pc_before + 32'd2);
      check("misalign_tied",    {31'b0, misalign}, 32'd0);
      hold(0, 1'b0, 32'h0);
`endif

      repeat (2) @(negedge clk);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached, expected completion");
      $fatal(1, "time limit");
   end

endmodule
